// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolver: builds a window from vertical column-strip slices and
// applies a loadable signed kernel through a 2-stage MAC with shift and saturation.
module conv3x3_stream #(
   parameter int PIX_WIDTH    = 8,
   parameter int COEF_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 10,
   parameter int IMAGE_HEIGHT = 10,
   parameter int SHIFT        = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_coef_load,
   input  logic [COEF_WIDTH-1:0] i_coef,
   input  logic                  i_valid,
   input  logic [PIX_WIDTH-1:0]  i_px0,
   input  logic [PIX_WIDTH-1:0]  i_px1,
   input  logic [PIX_WIDTH-1:0]  i_px2,
   output logic                  o_kernel_ready,
   output logic                  o_valid,
   output logic [PIX_WIDTH-1:0]  o_pixel,
   output logic                  o_strip_done,
   output logic                  o_frame_done
);

   localparam int unsigned PW  = PIX_WIDTH + COEF_WIDTH + 1;
   localparam int unsigned SW  = PW + 4;
   localparam int unsigned SCW = $clog2(IMAGE_HEIGHT);
   localparam int unsigned STW = $clog2(IMAGE_WIDTH);
   localparam logic signed [SW-1:0] MAXV = SW'((1 << PIX_WIDTH) - 1);

   typedef enum logic {LOAD_KERNEL, RUN} state_t;

   state_t                       r_state;
   logic signed [COEF_WIDTH-1:0] r_coef [9];
   logic [3:0]                   r_idx;
   logic [3*PIX_WIDTH-1:0]       r_win_top;
   logic [3*PIX_WIDTH-1:0]       r_win_mid;
   logic [SCW-1:0]               r_slice_cnt;
   logic [STW-1:0]               r_strip_cnt;
   logic signed [PW-1:0]         r_prod [9];
   logic                         r_s1_valid;
   logic                         r_s1_strip_last;
   logic                         r_s1_frame_last;

   logic [3*PIX_WIDTH-1:0]       w_slice;
   logic [PIX_WIDTH-1:0]         w_win [9];
   logic signed [PW-1:0]         w_prod [9];
   logic signed [SW-1:0]         w_sum;
   logic signed [SW-1:0]         w_shift;
   logic [PIX_WIDTH-1:0]         w_pix;
   logic                         w_accept;
   logic                         w_launch;
   logic                         w_strip_last;
   logic                         w_frame_last;
   logic [3:0]                   w_widx;

   assign w_slice        = {i_px0, i_px1, i_px2};
   assign o_kernel_ready = (r_state == RUN);
   assign w_accept       = (r_state == RUN) && i_valid && !i_coef_load;
   assign w_launch       = w_accept && (r_slice_cnt >= SCW'(2));
   assign w_strip_last   = (r_slice_cnt == SCW'(IMAGE_HEIGHT - 1));
   assign w_frame_last   = w_strip_last && (r_strip_cnt == STW'(IMAGE_WIDTH - 3));
   // A load beat while running is the first coefficient of a fresh kernel.
   assign w_widx         = (r_state == RUN) ? 4'd0 : r_idx;

   // Window rows: top/mid are the two previous slices, bottom is the incoming one.
   for (genvar c = 0; c < 3; c++) begin : g_col
      assign w_win[c]     = r_win_top[(2-c)*PIX_WIDTH +: PIX_WIDTH];
      assign w_win[3 + c] = r_win_mid[(2-c)*PIX_WIDTH +: PIX_WIDTH];
      assign w_win[6 + c] = w_slice[(2-c)*PIX_WIDTH +: PIX_WIDTH];
   end

   for (genvar i = 0; i < 9; i++) begin : g_mac
      assign w_prod[i] = $signed(PW'({1'b0, w_win[i]})) * PW'(r_coef[i]);
   end

   always_comb begin
      w_sum = SW'(r_prod[0]) + SW'(r_prod[1]) + SW'(r_prod[2])
            + SW'(r_prod[3]) + SW'(r_prod[4]) + SW'(r_prod[5])
            + SW'(r_prod[6]) + SW'(r_prod[7]) + SW'(r_prod[8]);
      w_shift = w_sum >>> SHIFT;
      w_pix   = w_shift[PIX_WIDTH-1:0];
      if (w_shift[SW-1]) begin
         w_pix = '0;
      end else if (w_shift > MAXV) begin
         w_pix = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= LOAD_KERNEL;
         r_coef          <= '{default: '0};
         r_idx           <= '0;
         r_win_top       <= '0;
         r_win_mid       <= '0;
         r_slice_cnt     <= '0;
         r_strip_cnt     <= '0;
         r_prod          <= '{default: '0};
         r_s1_valid      <= 1'b0;
         r_s1_strip_last <= 1'b0;
         r_s1_frame_last <= 1'b0;
         o_valid         <= 1'b0;
         o_pixel         <= '0;
         o_strip_done    <= 1'b0;
         o_frame_done    <= 1'b0;
      end else begin
         r_s1_valid      <= w_launch;
         r_s1_strip_last <= w_launch && w_strip_last;
         r_s1_frame_last <= w_launch && w_frame_last;
         if (w_launch) begin
            r_prod <= w_prod;
         end
         o_valid      <= r_s1_valid;
         o_strip_done <= r_s1_valid && r_s1_strip_last;
         o_frame_done <= r_s1_valid && r_s1_frame_last;
         if (r_s1_valid) begin
            o_pixel <= w_pix;
         end

         if (i_coef_load) begin
            r_coef[w_widx] <= i_coef;
            r_slice_cnt    <= '0;
            r_strip_cnt    <= '0;
            if (r_state == RUN) begin
               r_state <= LOAD_KERNEL;
               r_idx   <= 4'd1;
            end else if (r_idx == 4'd8) begin
               r_state <= RUN;
               r_idx   <= '0;
            end else begin
               r_idx <= r_idx + 4'd1;
            end
         end else if (w_accept) begin
            r_win_top <= r_win_mid;
            r_win_mid <= w_slice;
            if (w_strip_last) begin
               r_slice_cnt <= '0;
               r_strip_cnt <= w_frame_last ? '0 : r_strip_cnt + STW'(1);
            end else begin
               r_slice_cnt <= r_slice_cnt + SCW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: two instances (SHIFT=0 and SHIFT=3) share stimulus and are
// checked every cycle against a frame-level convolution model plus literal expectations.
module tb_conv3x3_stream;

   localparam int W = 10;
   localparam int H = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_coef_load = 1'b0;
   logic [7:0] i_coef = '0;
   logic       i_valid = 1'b0;
   logic [7:0] i_px0 = '0, i_px1 = '0, i_px2 = '0;
   logic       kr0, v0, sd0, fd0, kr3, v3, sd3, fd3;
   logic [7:0] p0, p3;

   always #5 clk = ~clk;

   conv3x3_stream #(.PIX_WIDTH(8), .COEF_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SHIFT(0)) u_dut0 (
      .clk(clk), .reset(reset), .i_coef_load(i_coef_load), .i_coef(i_coef), .i_valid(i_valid),
      .i_px0(i_px0), .i_px1(i_px1), .i_px2(i_px2), .o_kernel_ready(kr0), .o_valid(v0),
      .o_pixel(p0), .o_strip_done(sd0), .o_frame_done(fd0));

   conv3x3_stream #(.PIX_WIDTH(8), .COEF_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .SHIFT(3)) u_dut3 (
      .clk(clk), .reset(reset), .i_coef_load(i_coef_load), .i_coef(i_coef), .i_valid(i_valid),
      .i_px0(i_px0), .i_px1(i_px1), .i_px2(i_px2), .o_kernel_ready(kr3), .o_valid(v3),
      .o_pixel(p3), .o_strip_done(sd3), .o_frame_done(fd3));

   typedef struct {int sum; bit sd; bit fd; int due;} exp_t;

   exp_t q[$];
   int   log0[$];
   int   log3[$];
   int   ref_log[$];
   int   fr[H][W];
   int   k[9];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   bit   rst_q = 1'b1;
   logic [7:0] last0 = '0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   function automatic int sat(input int v, input int sh);
      int t;
      t = v >>> sh;
      if (t < 0) return 0;
      if (t > 255) return 255;
      return t;
   endfunction

   // Window whose newest (bottom) row is r, in strip s (columns s..s+2).
   function automatic int conv_sum(input int r, input int s);
      int acc;
      acc = 0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            acc += k[dr*3 + dc] * fr[r-2+dr][s+dc];
      return acc;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Per-cycle compare against the model queue.
   always @(negedge clk) begin
      if (chk_en) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            logic [10:0] exp0, exp3, act0, act3;
            e    = q.pop_front();
            exp0 = {1'b1, 8'(sat(e.sum, 0)), e.sd, e.fd};
            exp3 = {1'b1, 8'(sat(e.sum, 3)), e.sd, e.fd};
            act0 = {v0, p0, sd0, fd0};
            act3 = {v3, p3, sd3, fd3};
            n_tests += 2;
            if (act0 !== exp0) begin
               n_fail++;
               $display("FAIL out_shift0 cyc=%0d: got v/pix/sd/fd=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                        cyc, act0[10], act0[9:2], act0[1], act0[0], exp0[10], exp0[9:2], exp0[1], exp0[0]);
            end
            if (act3 !== exp3) begin
               n_fail++;
               $display("FAIL out_shift3 cyc=%0d: got v/pix/sd/fd=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                        cyc, act3[10], act3[9:2], act3[1], act3[0], exp3[10], exp3[9:2], exp3[1], exp3[0]);
            end
            if (v0) log0.push_back(int'(p0));
            if (v3) log3.push_back(int'(p3));
         end else begin
            n_tests++;
            if ({v0, sd0, fd0, v3, sd3, fd3} !== 6'b0) begin
               n_fail++;
               $display("FAIL idle cyc=%0d: got v0/sd0/fd0/v3/sd3/fd3=%b%b%b%b%b%b expected 000000",
                        cyc, v0, sd0, fd0, v3, sd3, fd3);
            end
            if (!rst_q) begin
               n_tests++;
               if (p0 !== last0) begin
                  n_fail++;
                  $display("FAIL hold cyc=%0d: got %0d expected %0d", cyc, p0, last0);
               end
            end
         end
         last0 = p0;
      end
   end

   task automatic drive_idle(input int n);
      i_valid     = 1'b0;
      i_coef_load = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Loads k[]; optionally the first beat carries a slice, and valid-only beats after pause_at.
   task automatic load_kernel(input bit first_valid, input int pause_at);
      for (int i = 0; i < 9; i++) begin
         i_coef_load = 1'b1;
         i_coef      = 8'(k[i]);
         i_valid     = first_valid && (i == 0);
         i_px0 = 8'd77; i_px1 = 8'd78; i_px2 = 8'd79;
         @(negedge clk);
         if (i == pause_at) begin
            i_coef_load = 1'b0;
            i_valid     = 1'b1;
            repeat (5) @(negedge clk);
         end
      end
      drive_idle(1);
   endtask

   task automatic send_frame(input int gap_pct, input int max_slices);
      int sent;
      sent = 0;
      for (int s = 0; s < W-2; s++) begin
         for (int r = 0; r < H; r++) begin
            if (sent == max_slices) begin
               i_valid = 1'b0;
               return;
            end
            while ($urandom_range(99) < gap_pct) drive_idle(1);
            i_coef_load = 1'b0;
            i_valid     = 1'b1;
            i_px0 = 8'(fr[r][s]); i_px1 = 8'(fr[r][s+1]); i_px2 = 8'(fr[r][s+2]);
            if (r >= 2) q.push_back('{conv_sum(r, s), r == H-1, (r == H-1) && (s == W-3), cyc + 2});
            sent++;
            @(negedge clk);
         end
      end
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check("drain_pending", q.size(), 0);
      q.delete();
      drive_idle(1);
   endtask

   task automatic set_kernel(input int centre, input int other);
      for (int i = 0; i < 9; i++) k[i] = (i == 4) ? centre : other;
   endtask

   task automatic set_frame_flat(input int v);
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = v;
   endtask

   task automatic clear_logs();
      log0.delete();
      log3.delete();
   endtask

   task automatic check_all(input string name, input int which, input int expv);
      int bad;
      bad = 0;
      for (int i = 0; i < ((which == 0) ? log0.size() : log3.size()); i++)
         if (((which == 0) ? log0[i] : log3[i]) != expv) bad++;
      check({name, "_count"}, (which == 0) ? log0.size() : log3.size(), 64);
      check({name, "_bad_values"}, bad, 0);
   endtask

   initial begin
      @(negedge clk);
      reset = 1'b1;
      drive_idle(2);
      check("reset_valid", int'({v0, v3}), 0);
      check("reset_pixel", int'(p0), 0);
      check("reset_flags", int'({sd0, fd0, sd3, fd3}), 0);
      check("reset_kready", int'({kr0, kr3}), 0);
      reset  = 1'b0;
      chk_en = 1'b1;

      // Identity on ramp, with slices offered mid-load (must be ignored).
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 10*r + c;
      set_kernel(1, 0);
      load_kernel(1'b0, 3);
      check("kready_after_load", int'({kr0, kr3}), 3);
      clear_logs();
      send_frame(0, 1000);
      drain();
      check("ramp_count", log0.size(), 64);
      if (log0.size() == 64) begin
         for (int j = 0; j < 8; j++) check("ramp_strip0", log0[j], 11 + 10*j);
         check("ramp_last", log0[63], 88);
         check("ramp_shift3_first", log3[0], 1);
      end
      ref_log = log0;

      // Same frame with random gaps must give the same pixels.
      clear_logs();
      send_frame(40, 1000);
      drain();
      check("gap_equal", int'(log0 == ref_log), 1);

      // Box kernel on flat 100.
      set_kernel(1, 1);
      set_frame_flat(100);
      load_kernel(1'b0, -1);
      clear_logs();
      send_frame(10, 1000);
      drain();
      check_all("box_shift3", 3, 112);
      check_all("box_shift0", 0, 255);

      // Laplacian on flat 200, then on an isolated 255.
      set_kernel(8, -1);
      set_frame_flat(200);
      load_kernel(1'b0, -1);
      clear_logs();
      send_frame(0, 1000);
      drain();
      check_all("lap_flat", 0, 0);
      set_frame_flat(0);
      fr[5][5] = 255;
      clear_logs();
      send_frame(0, 1000);
      drain();
      if (log0.size() == 64) begin
         check("lap_peak", log0[36], 255);
         check("lap_neighbour", log0[35], 0);
      end

      // Negative clamp.
      set_kernel(-1, 0);
      set_frame_flat(50);
      load_kernel(1'b0, -1);
      clear_logs();
      send_frame(20, 1000);
      drain();
      check_all("neg_clamp", 0, 0);

      // Random kernels and frames with gaps.
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(255)) - 128;
         for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = int'($urandom_range(255));
         load_kernel(1'b0, -1);
         send_frame(30, 1000);
         drain();
      end

      // Partial strip, then a reload whose first beat collides with a slice.
      send_frame(0, 5);
      for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(255)) - 128;
      load_kernel(1'b1, -1);
      send_frame(20, 1000);
      drain();

      // Reset after 30 slices: in-flight results are lost, kernel must reload.
      set_kernel(1, 0);
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 10*r + c;
      load_kernel(1'b0, -1);
      send_frame(0, 30);
      reset = 1'b1;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      drive_idle(1);
      reset = 1'b0;
      drive_idle(2);
      check("kready_after_reset", int'({kr0, kr3}), 0);
      load_kernel(1'b0, -1);
      clear_logs();
      send_frame(0, 1000);
      drain();
      check("reload_count", log0.size(), 64);
      if (log0.size() == 64) check("reload_first", log0[0], 11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
